// File: rtl/neopixel_receiver.sv
// WS2812 single-wire stream decoder: classifies bits by high-pulse width, assembles
// GRB words into a shadow frame and commits it to a readable display on the latch gap.
module neopixel_receiver #(
  parameter int NUM_PIXELS  = 8,
  parameter int CLK_NS      = 20,
  parameter int THRESH_NS   = 525,
  parameter int MIN_HIGH_NS = 150,
  parameter int MAX_HIGH_NS = 1000,
  parameter int LATCH_NS    = 40000,
  localparam int PIX_W      = $clog2(NUM_PIXELS)
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             neopixel_data,
  input  logic [PIX_W-1:0] rd_pixel,
  output logic [7:0]       rd_red,
  output logic [7:0]       rd_green,
  output logic [7:0]       rd_blue,
  output logic             frame_done,
  output logic [PIX_W:0]   pixels_received,
  output logic             overflow,
  output logic             error
);

  localparam logic [15:0]  THRESH_C = 16'(THRESH_NS / CLK_NS);
  localparam logic [15:0]  MIN_C    = 16'(MIN_HIGH_NS / CLK_NS);
  localparam logic [15:0]  MAX_C    = 16'(MAX_HIGH_NS / CLK_NS);
  localparam logic [15:0]  LATCH_C  = 16'(LATCH_NS / CLK_NS);
  localparam logic [PIX_W:0] NUM_C  = (PIX_W + 1)'(NUM_PIXELS);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, ERR} state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic        data_p0, data_p1, data_p2;
  logic        rise, fall, s_edge;
  logic [15:0] run_cnt;

  state_t state, state_nxt;
  logic   shift_en, bit_val, commit, discard, err_det;

  logic [22:0]           word_sr;
  logic [23:0]           word_nxt;
  logic [4:0]            bit_pos;
  logic [PIX_W:0]        pix_idx;
  logic                  frame_ovf;
  logic [NUM_PIXELS-1:0] wr_mask;
  logic [23:0]           shadow  [NUM_PIXELS];
  logic [23:0]           display [NUM_PIXELS];
  logic [23:0]           rd_word;

  // Stage p0/p1: two-flop synchronizer (data_p1 is the decoded line); p2 is the
  // previous sample for edge detection. run_cnt holds the length of the run just
  // ended on an edge cycle, and (cycles held - 1) on every other cycle.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      data_p0 <= 1'b0;
      data_p1 <= 1'b0;
      data_p2 <= 1'b0;
      run_cnt <= '0;
    end else begin
      data_p0 <= neopixel_data;
      data_p1 <= data_p0;
      data_p2 <= data_p1;
      run_cnt <= s_edge ? 16'd1 : sat_inc(run_cnt);
    end
  end

  assign rise   = data_p1 & ~data_p2;
  assign fall   = ~data_p1 & data_p2;
  assign s_edge = rise | fall;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    bit_val   = 1'b0;
    commit    = 1'b0;
    discard   = 1'b0;
    err_det   = 1'b0;
    case (state)
      IDLE: if (rise) state_nxt = HIGH;
      HIGH: begin
        if (fall) begin
          if (run_cnt < MIN_C) begin
            state_nxt = ERR;
            err_det   = 1'b1;
          end else begin
            shift_en  = 1'b1;
            bit_val   = (run_cnt >= THRESH_C);
            state_nxt = LOW;
          end
        end else if (run_cnt >= MAX_C) begin
          state_nxt = ERR;
          err_det   = 1'b1;
        end
      end
      LOW: begin
        if (rise) begin
          state_nxt = HIGH;
        end else if (run_cnt == LATCH_C - 16'd1) begin
          state_nxt = IDLE;
          if (bit_pos == 5'd0 && (pix_idx != '0 || frame_ovf)) begin
            commit = 1'b1;
          end else begin
            discard = 1'b1;
            err_det = 1'b1;
          end
        end
      end
      ERR: begin
        if (!data_p1 && !s_edge && run_cnt == LATCH_C - 16'd1) begin
          state_nxt = IDLE;
          discard   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign word_nxt = {word_sr, bit_val};

  // Frame assembly into the shadow store; words past the last slot only set frame_ovf.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      word_sr   <= '0;
      bit_pos   <= '0;
      pix_idx   <= '0;
      frame_ovf <= 1'b0;
      wr_mask   <= '0;
      for (int i = 0; i < NUM_PIXELS; i++) shadow[i] <= '0;
    end else if (commit || discard) begin
      word_sr   <= '0;
      bit_pos   <= '0;
      pix_idx   <= '0;
      frame_ovf <= 1'b0;
      wr_mask   <= '0;
    end else if (shift_en) begin
      word_sr <= word_nxt[22:0];
      if (bit_pos == 5'd23) begin
        bit_pos <= '0;
        if (pix_idx < NUM_C) begin
          shadow[pix_idx[PIX_W-1:0]]  <= word_nxt;
          wr_mask[pix_idx[PIX_W-1:0]] <= 1'b1;
          pix_idx                     <= pix_idx + (PIX_W + 1)'(1);
        end else begin
          frame_ovf <= 1'b1;
        end
      end else begin
        bit_pos <= bit_pos + 5'd1;
      end
    end
  end

  // Commit stage: only slots written this frame are copied, the rest keep old content.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      frame_done      <= 1'b0;
      error           <= 1'b0;
      pixels_received <= '0;
      overflow        <= 1'b0;
      for (int i = 0; i < NUM_PIXELS; i++) display[i] <= '0;
    end else begin
      frame_done <= commit;
      error      <= err_det;
      if (commit) begin
        for (int i = 0; i < NUM_PIXELS; i++) begin
          if (wr_mask[i]) display[i] <= shadow[i];
        end
        pixels_received <= pix_idx;
        overflow        <= frame_ovf;
      end
    end
  end

  assign rd_word  = display[rd_pixel];
  assign rd_green = rd_word[23:16];
  assign rd_red   = rd_word[15:8];
  assign rd_blue  = rd_word[7:0];

endmodule

// File: tb/tb_neopixel_receiver.sv
// Bench for neopixel_receiver: drives WS2812 waveforms and checks committed frames
// against a frame-level model built from the bit list sent.
module tb_neopixel_receiver;
  localparam int NP = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       din;
  logic [2:0] rd_pixel;
  logic [7:0] rd_red, rd_green, rd_blue;
  logic       frame_done, overflow, error;
  logic [3:0] pixels_received;

  int vectors = 0;
  int miscompares = 0;
  int fd_cnt = 0, err_cnt = 0;
  int fd_base = 0, err_base = 0;

  logic [23:0] m_disp [NP];
  int          m_pr;
  logic        m_ovf;
  bit          fbits[$];

  neopixel_receiver dut (
    .CLOCK_50        (clk),
    .reset           (rst),
    .neopixel_data   (din),
    .rd_pixel        (rd_pixel),
    .rd_red          (rd_red),
    .rd_green        (rd_green),
    .rd_blue         (rd_blue),
    .frame_done      (frame_done),
    .pixels_received (pixels_received),
    .overflow        (overflow),
    .error           (error)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_cnt++;
    if (error === 1'b1) err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input bit b, input int hi, input int lo, input bit record);
    din = 1'b1;
    cycles(hi);
    din = 1'b0;
    cycles(lo);
    if (record) fbits.push_back(b);
  endtask

  task automatic send_word(input logic [23:0] w);
    for (int i = 23; i >= 0; i--) begin
      if (w[i]) send_bit(1'b1, int'($urandom_range(45, 28)), int'($urandom_range(30, 12)), 1'b1);
      else      send_bit(1'b0, int'($urandom_range(22, 9)),  int'($urandom_range(35, 15)), 1'b1);
    end
  endtask

  task automatic latch(input int n);
    din = 1'b0;
    cycles(n);
  endtask

  task automatic mark();
    fd_base  = fd_cnt;
    err_base = err_cnt;
  endtask

  // Frame-level rules: whole words commit (first NP stored), partial words are an error.
  task automatic model_latch(output bit efd, output bit eerr);
    int n, px;
    logic [23:0] w;
    efd  = 1'b0;
    eerr = 1'b0;
    n    = fbits.size();
    if (n != 0) begin
      if (n % 24 != 0) begin
        eerr = 1'b1;
      end else begin
        px = n / 24;
        for (int k = 0; k < px && k < NP; k++) begin
          w = '0;
          for (int j = 0; j < 24; j++) w = {w[22:0], fbits[k * 24 + j]};
          m_disp[k] = w;
        end
        m_pr  = (px > NP) ? NP : px;
        m_ovf = (px > NP);
        efd   = 1'b1;
      end
    end
    fbits.delete();
  endtask

  task automatic check_frame(input string tag, input bit efd, input bit eerr);
    chk({tag, "_frame_done"}, 32'(fd_cnt - fd_base), 32'(efd));
    chk({tag, "_error"}, 32'(err_cnt - err_base), 32'(eerr));
    chk({tag, "_pixels"}, 32'(pixels_received), 32'(m_pr));
    chk({tag, "_overflow"}, 32'(overflow), 32'(m_ovf));
    for (int k = 0; k < NP; k++) begin
      rd_pixel = 3'(k);
      #1;
      chk($sformatf("%s_slot%0d", tag, k), 32'({rd_green, rd_red, rd_blue}), 32'(m_disp[k]));
    end
  endtask

  initial begin
    bit efd, eerr;
    int npx, extra;
    logic [23:0] w;

    rst = 1'b1;
    din = 1'b0;
    rd_pixel = '0;
    m_pr = 0;
    m_ovf = 1'b0;
    for (int k = 0; k < NP; k++) m_disp[k] = '0;
    cycles(3);
    chk("reset_pixels", 32'(pixels_received), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);
    chk("reset_frame_done", 32'(frame_done), 32'd0);
    chk("reset_error", 32'(error), 32'd0);
    rst = 1'b0;
    cycles(5);
    mark();
    check_frame("idle", 1'b0, 1'b0);

    // Eight-pixel pattern frame.
    mark();
    for (int k = 0; k < 8; k++) send_word({8'(k), 8'h80 | 8'(k), 8'hFF - 8'(k)});
    latch(2500);
    model_latch(efd, eerr);
    check_frame("pattern8", efd, eerr);
    rd_pixel = 3'd3;
    #1;
    chk("pattern8_red3", 32'(rd_red), 32'h83);
    chk("pattern8_green3", 32'(rd_green), 32'h03);
    chk("pattern8_blue3", 32'(rd_blue), 32'hFC);

    // Two frames: the shorter second frame must leave slot 1 alone.
    mark();
    send_word(24'h00FF00);
    send_word(24'h123456);
    latch(2100);
    model_latch(efd, eerr);
    check_frame("two_px", efd, eerr);
    mark();
    send_word(24'hABCDEF);
    latch(2100);
    model_latch(efd, eerr);
    check_frame("one_px", efd, eerr);
    rd_pixel = 3'd0;
    #1;
    chk("one_px_slot0_fixed", 32'({rd_green, rd_red, rd_blue}), 32'hABCDEF);
    rd_pixel = 3'd1;
    #1;
    chk("one_px_slot1_fixed", 32'({rd_green, rd_red, rd_blue}), 32'h123456);

    // Overflow: ten words into eight slots.
    mark();
    for (int k = 0; k < 10; k++) send_word(24'($urandom));
    latch(2100);
    model_latch(efd, eerr);
    check_frame("overflow10", efd, eerr);
    chk("overflow10_flag_fixed", 32'(overflow), 32'd1);

    // 30 bits: partial word at latch.
    mark();
    w = 24'($urandom);
    send_word(w);
    for (int i = 0; i < 6; i++) send_bit(w[i], 30, 20, 1'b1);
    latch(2100);
    model_latch(efd, eerr);
    check_frame("partial30", efd, eerr);

    // Glitch mid-word: 4-cycle high pulse.
    mark();
    for (int i = 0; i < 5; i++) send_bit(1'b1, 35, 30, 1'b1);
    send_bit(1'b1, 4, 1, 1'b0);
    latch(2100);
    fbits.delete();
    check_frame("glitch", 1'b0, 1'b1);

    // Width boundaries: 7/25 decode as 0, 26/50 decode as 1.
    mark();
    w = 24'($urandom);
    for (int i = 23; i >= 0; i--) begin
      if (w[i]) send_bit(1'b1, (i % 2 == 0) ? 26 : 50, 20, 1'b1);
      else      send_bit(1'b0, (i % 2 == 0) ? 25 : 7, 20, 1'b1);
    end
    latch(2100);
    model_latch(efd, eerr);
    check_frame("sweep", efd, eerr);

    // Stuck high for 60 cycles.
    mark();
    for (int i = 0; i < 3; i++) send_bit(1'b0, 17, 40, 1'b1);
    send_bit(1'b1, 60, 1, 1'b0);
    latch(2100);
    fbits.delete();
    check_frame("stuck_high", 1'b0, 1'b1);

    // Random frames, sometimes with a trailing partial word.
    for (int f = 0; f < 3; f++) begin
      mark();
      npx = int'($urandom_range(4, 1));
      extra = ($urandom_range(2, 0) == 0) ? int'($urandom_range(23, 1)) : 0;
      for (int k = 0; k < npx; k++) send_word(24'($urandom));
      for (int i = 0; i < extra; i++) send_bit(1'b0, 17, 40, 1'b1);
      latch(2100);
      model_latch(efd, eerr);
      check_frame($sformatf("random%0d", f), efd, eerr);
    end

    // Reset mid-frame after 12 bits.
    for (int i = 0; i < 12; i++) send_bit(1'b1, 35, 30, 1'b0);
    din = 1'b0;
    rst = 1'b1;
    cycles(1);
    chk("midrst_pixels", 32'(pixels_received), 32'd0);
    chk("midrst_overflow", 32'(overflow), 32'd0);
    rd_pixel = 3'd0;
    #1;
    chk("midrst_slot0", 32'({rd_green, rd_red, rd_blue}), 32'd0);
    cycles(2);
    rst = 1'b0;
    for (int k = 0; k < NP; k++) m_disp[k] = '0;
    m_pr = 0;
    m_ovf = 1'b0;
    fbits.delete();
    cycles(3);
    mark();
    send_word(24'($urandom));
    latch(2100);
    model_latch(efd, eerr);
    check_frame("after_rst", efd, eerr);
    chk("after_rst_pixels_fixed", 32'(pixels_received), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
